serv_dbus_ctrl: RTL and testbench
=================================

Name: serv_dbus_ctrl

Overview:
- Wishbone data-bus master for load/store traffic. Sits directly downstream of the memory-interface stage.
- Takes the core's load/store request (address, write data, byte lanes), runs exactly one Wishbone classic cycle, and captures read data.
- Returns a one-cycle completion strobe and registered read data, which feed back into bufreg2 for serial shifting.
- Only one transaction in flight; no pipelining.

Parameters:
- TIMEOUT_W, 8, width of bus-timeout counter. Used only when SERV_DBUS_TIMEOUT_EN is defined.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_req  in  1  core load/store request, level
- i_we  in  1  1=store, 0=load
- i_adr  in  32  byte address
- i_dat  in  32  store data, parallel
- i_sel  in  4  byte enables from memory-interface stage
- o_ack  out  1  one-cycle completion strobe to core
- o_err  out  1  bus error; valid only with o_ack
- o_rdt  out  32  captured load data
- o_busy  out  1  transaction in progress
- o_wb_adr  out  32  word-aligned address
- o_wb_dat  out  32  write data
- o_wb_sel  out  4  byte lane select
- o_wb_we  out  1  write enable
- o_wb_cyc  out  1  cycle
- o_wb_stb  out  1  strobe; always equal to o_wb_cyc
- i_wb_rdt  in  32  read data
- i_wb_ack  in  1  slave acknowledge
- i_wb_err  in  1  slave error

Behaviour:
- Reset: every output is 0. State = IDLE. All capture registers are cleared.
- FSM has three states: IDLE, BUS, RESP.
- IDLE:
  - If i_req=1, latch the request fields on that edge and go to BUS.
  - Latched fields: o_wb_adr={i_adr[31:2],2'b00}; o_wb_dat=i_dat; o_wb_sel=i_sel; o_wb_we=i_we.
- BUS:
  - o_wb_cyc=o_wb_stb=1 and o_busy=1, all registered.
  - Outputs are asserted the cycle after acceptance.
  - Address, data, sel and we stay stable for the whole cycle.
  - On i_wb_ack=1 or i_wb_err=1: deassert cyc/stb on the next edge and go to RESP.
  - If the access is a load and i_wb_ack=1, capture i_wb_rdt into o_rdt on that same edge.
  - If i_wb_err=1: set the error flag. o_rdt is left unchanged.
  - ack and err asserted together: err wins. No data is captured.
- RESP:
  - o_ack=1 for exactly one cycle. o_err = captured flag.
  - o_busy stays 1.
  - Next state is IDLE. The error flag clears on leaving RESP.
- Latency: request accepted at edge N → cyc high after N. Slave acks at edge M → o_ack high for the cycle after M. Minimum is 3 cycles from request to o_ack.
- i_req while o_busy=1 is ignored. The core must hold i_req until o_ack; re-acceptance happens only from IDLE.
- i_req still high in the cycle after o_ack starts a new transaction. This is legal back-to-back operation.
- o_rdt holds its value until the next successful load. Stores never modify o_rdt.
- i_wb_ack/i_wb_err outside BUS are ignored.
- Reset mid-transaction: cyc/stb drop asynchronously, no o_ack is issued, and the FSM returns to IDLE.

Optional Feature:
- Macro: SERV_DBUS_TIMEOUT_EN.
- Defined:
  - A TIMEOUT_W-bit counter clears on entering BUS and increments each BUS cycle.
  - When it reaches 2^TIMEOUT_W-1 with no ack/err, drop cyc/stb, set the error flag, and go to RESP.
  - The result is o_ack=1 with o_err=1, and o_rdt unchanged.
  - An ack arriving on the same cycle as terminal count takes priority: normal completion.
- Not defined: no counter logic; BUS waits indefinitely.

Test Plan:
- Load: i_req=1, i_we=0, i_adr=0x1003, i_sel=4'b1000. Slave acks 2 cycles after cyc with rdt=0xDEADBEEF. Required: o_wb_adr=0x1000, sel=4'b1000; o_ack pulses once; o_rdt=0xDEADBEEF; o_err=0.
- Store: i_we=1, i_dat=0x12345678, sel=4'b1111, zero-wait ack. Required: o_wb_we=1 and o_wb_dat=0x12345678 for the whole cycle; o_rdt unchanged; o_ack 3 cycles after request.
- Error: load with i_wb_err=1 and i_wb_ack=1 asserted together. Required: o_ack=1 with o_err=1; o_rdt keeps its prior value; next transaction has o_err=0.
- Back-to-back: i_req held high across 2 loads, with i_req toggling during BUS (ignored). Required: exactly 2 o_ack pulses; cyc drops for at least 1 cycle between the two Wishbone cycles.
- Reset mid-cycle: assert i_rst while cyc=1. Required: cyc/stb/o_busy go to 0 immediately (asynchronous); no o_ack; the next request completes normally.
- Timeout (SERV_DBUS_TIMEOUT_EN, TIMEOUT_W=4): slave never acks. Required: cyc drops after 15 BUS cycles; o_ack=1 and o_err=1. A second run with ack at cycle 15 completes with o_err=0.

Source files
------------

// File: rtl/serv_dbus_ctrl.sv
// serv_dbus_ctrl: single-outstanding Wishbone classic master for loads/stores.
// Define SERV_DBUS_TIMEOUT_EN to add a TIMEOUT_W-bit bus timeout.
module serv_dbus_ctrl #(
    parameter int TIMEOUT_W = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_adr,
    input  logic [31:0] i_dat,
    input  logic [3:0]  i_sel,
    output logic        o_ack,
    output logic        o_err,
    output logic [31:0] o_rdt,
    output logic        o_busy,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    input  logic        i_wb_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   tmo;
    logic   fail;
    logic   done;
    logic   unused_adr;

    assign unused_adr = ^i_adr[1:0];
    assign o_wb_stb   = o_wb_cyc;

`ifdef SERV_DBUS_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt;
    logic [TIMEOUT_W-1:0] cnt_nxt;

    assign cnt_nxt = cnt + TIMEOUT_W'(1);
    // Terminal count is hit on the edge where the counter would reach all-ones
    assign tmo     = (state == BUS) && (cnt_nxt == '1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (state == BUS) begin
            cnt <= cnt_nxt;
        end else begin
            cnt <= '0;
        end
    end
`else
    logic [TIMEOUT_W-1:0] unused_tw;

    assign unused_tw = '0;
    assign tmo       = 1'b0;
`endif

    // Slave error wins over ack; an ack beats a simultaneous timeout
    assign fail = i_wb_err | (tmo & ~i_wb_ack);
    assign done = i_wb_ack | fail;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            o_ack    <= 1'b0;
            o_err    <= 1'b0;
            o_rdt    <= '0;
            o_busy   <= 1'b0;
            o_wb_adr <= '0;
            o_wb_dat <= '0;
            o_wb_sel <= '0;
            o_wb_we  <= 1'b0;
            o_wb_cyc <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_req) begin
                        o_wb_adr <= {i_adr[31:2], 2'b00};
                        o_wb_dat <= i_dat;
                        o_wb_sel <= i_sel;
                        o_wb_we  <= i_we;
                        o_wb_cyc <= 1'b1;
                        o_busy   <= 1'b1;
                        state    <= BUS;
                    end
                end
                BUS: begin
                    if (done) begin
                        o_wb_cyc <= 1'b0;
                        o_ack    <= 1'b1;
                        o_err    <= fail;
                        state    <= RESP;
                        if (!o_wb_we && !fail) begin
                            o_rdt <= i_wb_rdt;
                        end
                    end
                end
                RESP: begin
                    o_ack  <= 1'b0;
                    o_err  <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    o_ack    <= 1'b0;
                    o_err    <= 1'b0;
                    o_busy   <= 1'b0;
                    o_wb_cyc <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serv_dbus_ctrl.sv
// tb_serv_dbus_ctrl: directed checks of the Wishbone load/store master.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_serv_dbus_ctrl;

`ifdef SERV_DBUS_TIMEOUT_EN
    localparam int TW = 4;
`else
    localparam int TW = 8;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        ack;
    logic        err;
    logic [31:0] rdt;
    logic        busy;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_stb;
    logic [31:0] wb_rdt;
    logic        wb_ack;
    logic        wb_err;

    int n_chk = 0;
    int n_bad = 0;
    int n_ack = 0;
    int base;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ack) n_ack++;
    end

    serv_dbus_ctrl #(.TIMEOUT_W(TW)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_req    (req),
        .i_we     (we),
        .i_adr    (adr),
        .i_dat    (dat),
        .i_sel    (sel),
        .o_ack    (ack),
        .o_err    (err),
        .o_rdt    (rdt),
        .o_busy   (busy),
        .o_wb_adr (wb_adr),
        .o_wb_dat (wb_dat),
        .o_wb_sel (wb_sel),
        .o_wb_we  (wb_we),
        .o_wb_cyc (wb_cyc),
        .o_wb_stb (wb_stb),
        .i_wb_rdt (wb_rdt),
        .i_wb_ack (wb_ack),
        .i_wb_err (wb_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic start(input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        req = 1'b1;
        we  = w;
        adr = a;
        dat = d;
        sel = s;
    endtask

    initial begin
        rst    = 1'b1;
        req    = 1'b0;
        we     = 1'b0;
        adr    = '0;
        dat    = '0;
        sel    = '0;
        wb_rdt = '0;
        wb_ack = 1'b0;
        wb_err = 1'b0;
        #2;
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rdt", rdt, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cyc", {30'd0, wb_cyc, wb_stb}, 32'd0);
        chk("rst_adr", wb_adr, 32'd0);
        nxt();
        nxt();
        rst = 1'b0;
        nxt();

        // load, ack two cycles after cyc rises
        start(1'b0, 32'h0000_1003, 32'h0, 4'b1000);
        base = n_ack;
        nxt();
        chk("ld_cyc", {30'd0, wb_cyc, wb_stb}, 32'd3);
        chk("ld_busy", {31'd0, busy}, 32'd1);
        chk("ld_adr", wb_adr, 32'h0000_1000);
        chk("ld_sel", {28'd0, wb_sel}, 32'h8);
        chk("ld_we", {31'd0, wb_we}, 32'd0);
        nxt();
        chk("ld_wait", {30'd0, wb_cyc, ack}, 32'd2);
        nxt();
        wb_ack = 1'b1;
        wb_rdt = 32'hDEAD_BEEF;
        nxt();
        wb_ack = 1'b0;
        req    = 1'b0;
        chk("ld_ack", {30'd0, ack, err}, 32'd2);
        chk("ld_rdt", rdt, 32'hDEAD_BEEF);
        chk("ld_resp", {30'd0, wb_cyc, busy}, 32'd1);
        nxt();
        chk("ld_idle", {30'd0, ack, busy}, 32'd0);
        chk("ld_pulses", n_ack - base, 32'd1);

        // store, zero-wait slave driving junk read data
        start(1'b1, 32'h0000_2000, 32'h1234_5678, 4'b1111);
        nxt();
        chk("st_we", {31'd0, wb_we}, 32'd1);
        chk("st_dat", wb_dat, 32'h1234_5678);
        chk("st_sel", {28'd0, wb_sel}, 32'hF);
        chk("st_noack", {31'd0, ack}, 32'd0);
        wb_ack = 1'b1;
        wb_rdt = 32'h5555_5555;
        nxt();
        wb_ack = 1'b0;
        req    = 1'b0;
        chk("st_ack", {30'd0, ack, err}, 32'd2);
        chk("st_rdt", rdt, 32'hDEAD_BEEF);
        chk("st_dat_hold", wb_dat, 32'h1234_5678);
        nxt();

        // ack and err together on a load
        start(1'b0, 32'h0000_3000, 32'h0, 4'b1111);
        nxt();
        wb_ack = 1'b1;
        wb_err = 1'b1;
        wb_rdt = 32'hBAD0_BAD0;
        nxt();
        wb_ack = 1'b0;
        wb_err = 1'b0;
        req    = 1'b0;
        chk("er_ack", {30'd0, ack, err}, 32'd3);
        chk("er_rdt", rdt, 32'hDEAD_BEEF);
        nxt();
        chk("er_clr", {30'd0, ack, err}, 32'd0);
        start(1'b0, 32'h0000_3004, 32'h0, 4'b1111);
        nxt();
        wb_ack = 1'b1;
        wb_rdt = 32'hCAFE_F00D;
        nxt();
        wb_ack = 1'b0;
        req    = 1'b0;
        chk("er_next", {30'd0, ack, err}, 32'd2);
        chk("er_next_rdt", rdt, 32'hCAFE_F00D);
        nxt();

        // back-to-back loads with i_req held, toggled during BUS
        base = n_ack;
        start(1'b0, 32'h0000_4000, 32'h0, 4'b1111);
        nxt();
        req = 1'b0;
        nxt();
        req    = 1'b1;
        wb_ack = 1'b1;
        wb_rdt = 32'h1111_1111;
        nxt();
        wb_ack = 1'b0;
        adr    = 32'h0000_4012;
        chk("bb_ack1", {30'd0, ack, wb_cyc}, 32'd2);
        chk("bb_rdt1", rdt, 32'h1111_1111);
        nxt();
        chk("bb_gap", {29'd0, wb_cyc, busy, ack}, 32'd0);
        nxt();
        chk("bb_cyc2", {31'd0, wb_cyc}, 32'd1);
        chk("bb_adr2", wb_adr, 32'h0000_4010);
        wb_ack = 1'b1;
        wb_rdt = 32'h2222_2222;
        nxt();
        wb_ack = 1'b0;
        req    = 1'b0;
        chk("bb_rdt2", rdt, 32'h2222_2222);
        nxt();
        chk("bb_pulses", n_ack - base, 32'd2);
        chk("bb_end", {30'd0, wb_cyc, busy}, 32'd0);

        // asynchronous reset while cyc is high
        start(1'b0, 32'h0000_5000, 32'h0, 4'b1111);
        nxt();
        chk("rm_cyc", {31'd0, wb_cyc}, 32'd1);
        base = n_ack;
        #2;
        rst = 1'b1;
        #1;
        chk("rm_drop", {29'd0, wb_cyc, wb_stb, busy}, 32'd0);
        nxt();
        rst = 1'b0;
        req = 1'b0;
        nxt();
        nxt();
        chk("rm_noack", n_ack - base, 32'd0);
        start(1'b0, 32'h0000_5004, 32'h0, 4'b1111);
        nxt();
        wb_ack = 1'b1;
        wb_rdt = 32'h600D_F00D;
        nxt();
        wb_ack = 1'b0;
        req    = 1'b0;
        chk("rm_ack", {30'd0, ack, err}, 32'd2);
        chk("rm_rdt", rdt, 32'h600D_F00D);
        nxt();

`ifdef SERV_DBUS_TIMEOUT_EN
        // silent slave: cyc held for 15 BUS cycles, then error
        start(1'b0, 32'h0000_6000, 32'h0, 4'b1111);
        for (int k = 1; k <= 15; k++) begin
            nxt();
            chk("to_cyc", {31'd0, wb_cyc}, 32'd1);
        end
        nxt();
        req = 1'b0;
        chk("to_ack", {29'd0, wb_cyc, ack, err}, 32'd3);
        chk("to_rdt", rdt, 32'h600D_F00D);
        nxt();
        // ack on the terminal-count cycle completes normally
        start(1'b0, 32'h0000_6004, 32'h0, 4'b1111);
        for (int k = 1; k <= 15; k++) begin
            nxt();
            if (k == 15) begin
                wb_ack = 1'b1;
                wb_rdt = 32'h7777_7777;
            end
        end
        nxt();
        wb_ack = 1'b0;
        req    = 1'b0;
        chk("to_ok", {30'd0, ack, err}, 32'd2);
        chk("to_ok_rdt", rdt, 32'h7777_7777);
        nxt();
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
